matrix_multiplier: RTL and testbench

Sequential integer matrix multiplier that computes C = A × B for small row-major matrices. It sits behind the serial matrix loader, which supplies both operand arrays, the four dimension nibbles and a ready level. The block also provides the loader's 4-bit input register, which delays the incoming data nibble by one clock. It uses one multiply-accumulate (MAC) per clock and a small FSM.

---
 rtl/matrix_multiplier.sv | 146 ++++++++++++++
 tb/tb_matrix_multiplier.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/matrix_multiplier.sv
// matrix_multiplier: sequential C = A x B over row-major operands with one MAC per clock, plus the loader's one-clock data nibble register.
// Ports: CLK/RST_N clock and async active-low reset; data -> data_q one-clock nibble delay;
//        matrix_1/matrix_2 packed operands, R1/C1/R2/C2 dimensions, readybit start level;
//        result packed product, busy (computing), done (result or error valid), dim_err (dimensions rejected).
module matrix_multiplier #(
    parameter int DEPTH  = 5,
    parameter int DATA_W = 32
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [3:0]                data,
    output logic [3:0]                data_q,
    input  logic [DEPTH*DATA_W-1:0]   matrix_1,
    input  logic [DEPTH*DATA_W-1:0]   matrix_2,
    input  logic [3:0]                R1,
    input  logic [3:0]                C1,
    input  logic [3:0]                R2,
    input  logic [3:0]                C2,
    input  logic                      readybit,
    output logic [DEPTH*DATA_W-1:0]   result,
    output logic                      busy,
    output logic                      done,
    output logic                      dim_err
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q [DEPTH];
    logic [DATA_W-1:0] a_d [DEPTH];
    logic [DATA_W-1:0] b_q [DEPTH];
    logic [DATA_W-1:0] b_d [DEPTH];
    logic [DATA_W-1:0] res_q [DEPTH];
    logic [DATA_W-1:0] res_d [DEPTH];
    logic [3:0]        r1_q, r1_d, c1_q, c1_d, c2_q, c2_d;
    logic [3:0]        i_q, i_d, j_q, j_d, k_q, k_d;
    logic [DATA_W-1:0] acc_q, acc_d, prod, sum;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [IW-1:0]     a_idx, b_idx, r_idx;
    logic              dims_ok;
    always_comb begin
        a_idx   = IW'(int'(i_q) * int'(c1_q) + int'(k_q));
        b_idx   = IW'(int'(k_q) * int'(c2_q) + int'(j_q));
        r_idx   = IW'(int'(i_q) * int'(c2_q) + int'(j_q));
        prod    = a_q[a_idx] * b_q[b_idx];
        sum     = acc_q + prod;
        dims_ok = R1 != 0 && C1 != 0 && R2 != 0 && C2 != 0 && C1 == R2 &&
                  int'(R1) * int'(C1) <= DEPTH && int'(R2) * int'(C2) <= DEPTH &&
                  int'(R1) * int'(C2) <= DEPTH;
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        r1_d    = r1_q;
        c1_d    = c1_q;
        c2_d    = c2_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (readybit) begin
                for (int e = 0; e < DEPTH; e++) begin
                    a_d[e]   = matrix_1[DATA_W*e +: DATA_W];
                    b_d[e]   = matrix_2[DATA_W*e +: DATA_W];
                    res_d[e] = '0;
                end
                r1_d    = R1;
                c1_d    = C1;
                c2_d    = C2;
                i_d     = '0;
                j_d     = '0;
                k_d     = '0;
                acc_d   = '0;
                busy_d  = dims_ok;
                err_d   = !dims_ok;
                state_d = dims_ok ? CALC : DONE;
            end
            CALC: if (k_q == c1_q - 4'd1) begin
                res_d[r_idx] = sum;
                acc_d        = '0;
                k_d          = '0;
                j_d          = j_q == c2_q - 4'd1 ? 4'd0 : j_q + 4'd1;
                if (j_q == c2_q - 4'd1) begin
                    i_d = i_q + 4'd1;
                    if (i_q == r1_q - 4'd1) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                    end
                end
            end else begin
                acc_d = sum;
                k_d   = k_q + 4'd1;
            end
            default: begin
                // done registers one edge after entering DONE; dropping readybit releases both flags
                done_d  = readybit;
                err_d   = readybit & err_q;
                state_d = readybit ? DONE : IDLE;
            end
        endcase
    end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            a_q     <= '{default: '0};
            b_q     <= '{default: '0};
            res_q   <= '{default: '0};
            r1_q    <= '0;
            c1_q    <= '0;
            c2_q    <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            r1_q    <= r1_d;
            c1_q    <= c1_d;
            c2_q    <= c2_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            data_q  <= data;
        end
    end
    for (genvar g = 0; g < DEPTH; g++) begin : g_pack
        assign result[DATA_W*g +: DATA_W] = res_q[g];
    end
    assign busy    = busy_q;
    assign done    = done_q;
    assign dim_err = err_q;
endmodule

// File: tb/tb_matrix_multiplier.sv
// tb_matrix_multiplier: randomized and directed checks of matrix_multiplier against a loop-based matrix product model.
module tb_matrix_multiplier;
    localparam int DEPTH = 5;
    localparam int DW    = 32;
    localparam int RW    = DEPTH * DW;
    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          readybit = 1'b0;
    logic [3:0]    data = '0;
    logic [3:0]    data_q;
    logic [3:0]    R1 = '0, C1 = '0, R2 = '0, C2 = '0;
    logic [RW-1:0] matrix_1 = '0, matrix_2 = '0;
    logic [RW-1:0] result;
    logic          busy, done, dim_err;
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] am [DEPTH];
    logic [DW-1:0] bm [DEPTH];
    always #5 CLK = ~CLK;
    matrix_multiplier #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
        .CLK(CLK), .RST_N(RST_N), .data(data), .data_q(data_q),
        .matrix_1(matrix_1), .matrix_2(matrix_2),
        .R1(R1), .C1(C1), .R2(R2), .C2(C2), .readybit(readybit),
        .result(result), .busy(busy), .done(done), .dim_err(dim_err)
    );
    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge CLK);
        #1;
    endtask
    function automatic bit dims_valid(input int r1, input int c1, input int r2, input int c2);
        return r1 > 0 && c1 > 0 && r2 > 0 && c2 > 0 && c1 == r2 &&
               r1 * c1 <= DEPTH && r2 * c2 <= DEPTH && r1 * c2 <= DEPTH;
    endfunction
    function automatic logic [RW-1:0] model(input int r1, input int c1, input int r2, input int c2);
        logic [RW-1:0] c;
        logic [DW-1:0] s;
        c = '0;
        if (!dims_valid(r1, c1, r2, c2)) return c;
        for (int i = 0; i < r1; i++)
            for (int j = 0; j < c2; j++) begin
                s = '0;
                for (int k = 0; k < c1; k++) s = s + am[i*c1+k] * bm[k*c2+j];
                c[(i*c2+j)*DW +: DW] = s;
            end
        return c;
    endfunction
    task automatic run(input string tag, input int r1, input int c1, input int r2, input int c2);
        logic [RW-1:0] exp;
        int cyc, bsy, n;
        bit ok;
        ok  = dims_valid(r1, c1, r2, c2);
        n   = ok ? r1 * c2 * c1 + 1 : 1;
        exp = model(r1, c1, r2, c2);
        for (int e = 0; e < DEPTH; e++) begin
            matrix_1[e*DW +: DW] = am[e];
            matrix_2[e*DW +: DW] = bm[e];
        end
        R1 = 4'(r1);
        C1 = 4'(c1);
        R2 = 4'(r2);
        C2 = 4'(c2);
        readybit = 1'b1;
        tick;
        matrix_1 = ~matrix_1;
        matrix_2 = {RW{1'b1}};
        R1 = 4'(r1 + 1);
        cyc = 0;
        bsy = 0;
        while (!done && cyc < 400) begin
            bsy += int'(busy);
            tick;
            cyc++;
        end
        check({tag, " latency"}, RW'(cyc), RW'(n));
        check({tag, " busy_cycles"}, RW'(bsy), RW'(ok ? n - 1 : 0));
        check({tag, " result"}, result, exp);
        check({tag, " dim_err"}, RW'(dim_err), RW'(!ok));
        repeat (3) tick;
        check({tag, " hold_no_restart"}, RW'({done, busy}), RW'(2'b10));
        readybit = 1'b0;
        tick;
        check({tag, " release_flags"}, RW'({done, dim_err, busy}), RW'(0));
        check({tag, " result_held"}, result, exp);
    endtask
    initial begin
        tick;
        tick;
        check("reset_outputs", {result[RW-1:8], data_q, 1'b0, busy, done, dim_err}, '0);
        RST_N = 1'b1;
        check("data_q_after_reset", RW'(data_q), RW'(0));
        for (int v = 1; v <= 4; v++) begin
            data = 4'(v);
            tick;
            check("data_q_delay", RW'(data_q), RW'(v));
        end
        check("idle_flags", RW'({busy, done, dim_err}), RW'(0));
        am = '{1, 2, 3, 4, 0};
        bm = '{5, 6, 7, 8, 0};
        run("mul2x2", 2, 2, 2, 2);
        check("mul2x2_const", result, {32'd0, 32'd50, 32'd43, 32'd22, 32'd19});
        bm = '{1, 1, 1, 1, 0};
        run("mul1x4", 1, 4, 4, 1);
        check("mul1x4_const", result, RW'(10));
        run("dim_mismatch", 2, 2, 3, 1);
        am = '{32'hFFFF_FFFF, 0, 0, 0, 0};
        bm = '{2, 0, 0, 0, 0};
        run("trunc", 1, 1, 1, 1);
        check("trunc_const", result, RW'(32'hFFFF_FFFE));
        am = '{1, 2, 3, 4, 0};
        bm = '{5, 6, 7, 8, 0};
        for (int e = 0; e < DEPTH; e++) begin
            matrix_1[e*DW +: DW] = am[e];
            matrix_2[e*DW +: DW] = bm[e];
        end
        R1 = 4'd2; C1 = 4'd2; R2 = 4'd2; C2 = 4'd2;
        readybit = 1'b1;
        repeat (4) tick;
        RST_N = 1'b0;
        #1;
        check("async_reset_abort", {result[RW-1:8], data_q, 1'b0, busy, done, dim_err}, '0);
        readybit = 1'b0;
        tick;
        RST_N = 1'b1;
        tick;
        run("after_reset", 2, 2, 2, 2);
        for (int t = 0; t < 25; t++) begin
            int r1, c1, r2, c2;
            r1 = int'($urandom_range(1, 3));
            c1 = int'($urandom_range(1, 3));
            c2 = int'($urandom_range(1, 3));
            r2 = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 3)) : c1;
            for (int e = 0; e < DEPTH; e++) begin
                am[e] = $urandom;
                bm[e] = $urandom;
            end
            run($sformatf("rand%0d_%0dx%0dx%0dx%0d", t, r1, c1, r2, c2), r1, c1, r2, c2);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
